// File: rtl/ingreso_clave.sv
// Keypad entry stage: collects BCD digits while a vehicle is present and
// presents the packed code with a one-cycle valid pulse, aborting stale entries.
module ingreso_clave #(
    parameter  int DIGITS         = 4,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                vehicle_present,
    input  logic                key_valid,
    input  logic [3:0]          key_digit,
    input  logic                key_clear,
    output logic [4*DIGITS-1:0] code,
    output logic                code_valid,
    output logic [2:0]          digit_count,
    output logic                bad_digit,
    output logic                entry_timeout
);

    localparam int             CW   = 4 * DIGITS;
    localparam logic [2:0]     LAST = 3'(DIGITS - 1);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, ABORT} state_t;

    state_t          state_q;
    logic [CW-1:0]   code_q;
    logic [2:0]      count_q;
    logic [TW-1:0]   timer_q;
    logic            key_q;
    logic            primed_q;
    logic            code_valid_q;
    logic            bad_digit_q;
    logic            entry_timeout_q;

    logic            key_event;
    logic            digit_ok;
    logic [TW-1:0]   timer_inc;
    logic [CW-1:0]   code_base;
    logic [CW-1:0]   code_shifted;

    // The first sample after reset only establishes the baseline, so a strobe
    // already high at release is not taken as a fresh key.
    assign key_event = primed_q & key_valid & ~key_q;
    assign digit_ok  = (key_digit <= 4'd9);
    assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);

    always_comb begin
        code_base    = (count_q == 3'd0) ? '0 : code_q;
        code_shifted = {code_base[CW-5:0], key_digit};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            code_q          <= '0;
            count_q         <= '0;
            timer_q         <= '0;
            key_q           <= 1'b0;
            primed_q        <= 1'b0;
            code_valid_q    <= 1'b0;
            bad_digit_q     <= 1'b0;
            entry_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees start-of-cycle state.
            key_q           <= key_valid;
            primed_q        <= 1'b1;
            code_valid_q    <= 1'b0;
            bad_digit_q     <= 1'b0;
            entry_timeout_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (vehicle_present) begin
                        state_q <= COLLECT;
                        timer_q <= '0;
                    end
                end

                COLLECT: begin
                    if (!vehicle_present) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        code_q  <= '0;
                        timer_q <= '0;
                    end else if (key_clear) begin
                        count_q <= '0;
                        code_q  <= '0;
                        timer_q <= '0;
                    end else if (key_event && digit_ok) begin
                        code_q  <= code_shifted;
                        count_q <= count_q + 3'd1;
                        timer_q <= '0;
                        if (count_q == LAST) begin
                            state_q <= DONE;
                        end
                    end else begin
                        // A rejected key is not activity: the idle timer keeps running.
                        if (key_event) begin
                            bad_digit_q <= 1'b1;
                        end
                        timer_q <= timer_inc;
                        if (timer_inc == TMAX) begin
                            state_q <= ABORT;
                        end
                    end
                end

                DONE: begin
                    code_valid_q <= 1'b1;
                    count_q      <= '0;
                    timer_q      <= '0;
                    state_q      <= vehicle_present ? COLLECT : IDLE;
                end

                ABORT: begin
                    entry_timeout_q <= 1'b1;
                    count_q         <= '0;
                    code_q          <= '0;
                    timer_q         <= '0;
                    state_q         <= vehicle_present ? COLLECT : IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign code          = code_q;
    assign code_valid    = code_valid_q;
    assign digit_count   = count_q;
    assign bad_digit     = bad_digit_q;
    assign entry_timeout = entry_timeout_q;

endmodule
